// File: rtl/cdc_pkg.sv
// Shared types and constants for the toggle req/ack clock-domain crossing.
package cdc_pkg;

  // Source-side handshake FSM states.
  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    WAIT_ACK = 1'b1
  } state_e;

  // Fewer flops than this does not give a usable metastability settling window.
  localparam int SYNC_STAGES_MIN = 2;

  // Wait-counter width: one bit of headroom so the saturated value always lies
  // above TIMEOUT-1, which makes the timeout match fire once per transfer.
  function automatic int cnt_width(input int timeout);
    return $clog2(timeout + 1) + 1;
  endfunction

endpackage

// File: rtl/cdc_sync_bit.sv
// Single-bit multi-flop synchronizer with async active-high reset.
// Used on the returning ack toggle; the receive side can reuse it for req.
module cdc_sync_bit
  import cdc_pkg::*;
#(
  parameter int STAGES = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  // Requests below the minimum depth are raised to it rather than silently
  // producing a chain too short to be safe.
  localparam int N = (STAGES < SYNC_STAGES_MIN) ? SYNC_STAGES_MIN : STAGES;

  logic [N-1:0] chain;

  // Shift the asynchronous input through the chain; only the last flop is used.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) chain <= '0;
    else       chain <= {chain[N-2:0], d};
  end

  assign q = chain[N-1];

endmodule

// File: rtl/cdc_handshake_tx.sv
// Source half of a two-phase (toggle) req/ack crossing for a DW-bit word.
// A word is captured into tx_data, tx_req toggles, and the block waits until
// the synchronized ack toggle catches up with tx_req before taking the next one.
module cdc_handshake_tx
  import cdc_pkg::*;
#(
  parameter int DW          = 32,
  parameter int SYNC_STAGES = 3,
  parameter int TIMEOUT     = 0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic [DW-1:0] tx_data,
  output logic          tx_req,
  input  logic          tx_ack,
  output logic          done,
  output logic          timeout,
  output logic          proto_err
);

  localparam int CW = cnt_width(TIMEOUT);

  state_e        state, state_nxt;
  logic [CW-1:0] cnt;
  logic          ack_s;
  logic          ack_match;
  logic          accept;
  logic          perr_armed;
  logic          perr_fire;

  // The raw ack never touches logic; only the synchronized copy does.
  cdc_sync_bit #(
    .STAGES (SYNC_STAGES)
  ) u_ack_sync (
    .clk   (clk),
    .reset (reset),
    .d     (tx_ack),
    .q     (ack_s)
  );

  // With two-phase signalling a transfer is complete when ack has caught up with req.
  assign ack_match = (ack_s == tx_req);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state, ready and accept decode.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept    = 1'b1;
          state_nxt = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (ack_match) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Crossing outputs come straight from these flops; they only change on accept,
  // so they are stable for the whole time the far side may be sampling them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_data <= '0;
      tx_req  <= 1'b0;
    end else if (accept) begin
      tx_data <= in_data;
      tx_req  <= ~tx_req;
    end
  end

  // Cycles spent waiting for ack; saturates so a hung transfer cannot wrap
  // around and pulse timeout a second time.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                  cnt <= '0;
    else if (accept)                            cnt <= '0;
    else if (state == WAIT_ACK && cnt != '1)    cnt <= cnt + 1'b1;
  end

  // Completion pulse lands in the first IDLE cycle, alongside in_ready.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) done <= 1'b0;
    else       done <= (state == WAIT_ACK) && ack_match;
  end

  // An ack toggle while idle is reported once, then ignored until ack and req
  // agree again, so a single stray toggle yields a single error pulse.
  assign perr_fire = (state == IDLE) && !ack_match && perr_armed;

  // Error pulse register and its re-arm flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      proto_err  <= 1'b0;
      perr_armed <= 1'b1;
    end else begin
      proto_err <= perr_fire;
      if (ack_match)      perr_armed <= 1'b1;
      else if (perr_fire) perr_armed <= 1'b0;
    end
  end

  // Timeout is advisory only: the block keeps waiting, because abandoning a
  // toggle handshake mid-flight would desynchronize req and ack.
  // An ack arriving in the threshold cycle wins and the pulse is suppressed.
  generate
    if (TIMEOUT == 0) begin : g_no_timeout
      assign timeout = 1'b0;
    end else begin : g_timeout
      assign timeout = (state == WAIT_ACK) && (cnt == CW'(TIMEOUT - 1)) && !ack_match;
    end
  endgenerate

endmodule

// File: tb/tb_cdc_handshake_tx.sv
// Directed bench for cdc_handshake_tx with a cycle-level reference model.
module tb_cdc_handshake_tx;

  localparam int DW = 32;
  localparam int S  = 3;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic [DW-1:0] tx_data;
  logic          tx_req;
  logic          tx_ack;
  logic          done;
  logic          timeout;
  logic          proto_err;

  always #5 clk = ~clk;

  cdc_handshake_tx #(
    .DW          (DW),
    .SYNC_STAGES (S),
    .TIMEOUT     (TO)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .tx_data   (tx_data),
    .tx_req    (tx_req),
    .tx_ack    (tx_ack),
    .done      (done),
    .timeout   (timeout),
    .proto_err (proto_err)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference model. Time is counted in clock edges since reset; the tx_ack
  // value seen at every edge is logged, and the synchronized ack is simply the
  // sample taken S-1 edges earlier (0 until that many edges have passed).
  logic          samp [0:4095];
  int            k, ka;
  bit            m_busy, m_req, m_done, m_perr, m_armed;
  logic [DW-1:0] m_data;

  function automatic logic ack_after(input int e);
    if (e < S) return 1'b0;
    return samp[(e - S + 1) % 4096];
  endfunction

  // At each falling edge: compare DUT against the model, then predict the
  // effect of the coming rising edge from the inputs now being presented.
  always @(negedge clk) begin
    logic asp;
    logic m_to;
    if (reset) begin
      k = 0; ka = 0;
      m_busy = 0; m_req = 0; m_data = '0;
      m_done = 0; m_perr = 0; m_armed = 1;
    end
    asp  = ack_after(k);
    m_to = m_busy && ((k - ka + 1) == TO) && (asp != m_req);
    chk("m_in_ready",  in_ready,  !m_busy);
    chk("m_tx_req",    tx_req,    m_req);
    chk("m_tx_data",   tx_data,   m_data);
    chk("m_done",      done,      m_done);
    chk("m_proto_err", proto_err, m_perr);
    chk("m_timeout",   timeout,   m_to);
    if (!reset) begin
      k++;
      samp[k % 4096] = tx_ack;
      m_done = m_busy && (asp == m_req);
      m_perr = !m_busy && (asp != m_req) && m_armed;
      if (asp == m_req) m_armed = 1;
      else if (m_perr)  m_armed = 0;
      if (!m_busy) begin
        if (in_valid) begin
          m_busy = 1; m_req = ~m_req; m_data = in_data; ka = k;
        end
      end else if (asp == m_req) begin
        m_busy = 0;
      end
    end
  end

  // Records every req toggle and the word it carried while enabled.
  bit            mon_en = 0;
  logic          last_req = 1'b0;
  int            n_tog = 0;
  logic [DW-1:0] dq [$];

  always @(negedge clk) begin
    if (mon_en && tx_req !== last_req) begin
      n_tog++;
      dq.push_back(tx_data);
    end
    last_req = tx_req;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_ready(input string nm);
    int n = 0;
    while (!in_ready && n < 40) begin
      tick();
      n++;
    end
    chk(nm, in_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_to, first, n_pe, n_done;
    reset = 1'b1; in_valid = 1'b0; in_data = '0; tx_ack = 1'b0;
    tick(); tick();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_tx_req",   tx_req,   0);
    chk("rst_tx_data",  tx_data,  0);
    chk("rst_done",     done,     0);
    chk("rst_perr",     proto_err, 0);
    reset = 1'b0;
    tick();

    // 1: accept first word
    in_valid = 1'b1; in_data = 32'hA5A5_0001;
    tick();
    in_valid = 1'b0;
    chk("t1_tx_req",   tx_req,   1);
    chk("t1_tx_data",  tx_data,  32'hA5A5_0001);
    chk("t1_in_ready", in_ready, 0);

    // 2: ack toggle sampled at edge N completes at edge N+3
    tx_ack = 1'b1;
    tick(); chk("t2_done_n0", done, 0);
    tick(); chk("t2_done_n1", done, 0);
    tick(); chk("t2_done_n2", done, 0);
    chk("t2_hold_data", tx_data, 32'hA5A5_0001);
    tick(); chk("t2_done_n3", done, 1);
    chk("t2_ready_n3", in_ready, 1);
    tick(); chk("t2_done_n4", done, 0);

    // 3: back-to-back words 1,2,3 with ack 2 cycles after each req
    mon_en = 1;
    for (int w = 1; w <= 3; w++) begin
      in_data = DW'(w); in_valid = 1'b1;
      wait_ready("t3_ready");
      tick();
      tick(); tick();
      tx_ack = ~tx_ack;
    end
    in_valid = 1'b0;
    wait_ready("t3_last_ready");
    tick(); tick();
    mon_en = 0;
    chk("t3_toggles", n_tog, 3);
    chk("t3_count", dq.size(), 3);
    if (dq.size() == 3) begin
      chk("t3_word0", dq[0], 1);
      chk("t3_word1", dq[1], 2);
      chk("t3_word2", dq[2], 3);
    end

    // 4: timeout after 16 waiting cycles, late ack still completes
    in_data = 32'h0000_0044; in_valid = 1'b1;
    wait_ready("t4_ready");
    tick();
    in_valid = 1'b0;
    n_to = 0; first = 0;
    for (int i = 1; i <= 24; i++) begin
      if (timeout) begin
        n_to++;
        if (first == 0) first = i;
      end
      tick();
    end
    chk("t4_to_count", n_to, 1);
    chk("t4_to_cycle", first, 16);
    chk("t4_still_busy", in_ready, 0);
    tx_ack = ~tx_ack;
    n_done = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (done) n_done++;
      if (timeout) n_to++;
    end
    chk("t4_late_done", n_done, 1);
    chk("t4_to_total", n_to, 1);

    // 5: stray ack toggle while idle
    tx_ack = ~tx_ack;
    n_pe = 0; first = 0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (proto_err) begin
        n_pe++;
        if (first == 0) first = i;
      end
    end
    chk("t5_perr_count", n_pe, 1);
    chk("t5_perr_edge",  first, 4);
    chk("t5_tx_req",     tx_req, 1);
    chk("t5_tx_data",    tx_data, 32'h0000_0044);
    chk("t5_in_ready",   in_ready, 1);

    // 6: reset during WAIT_ACK, then a stale ack arrives
    reset = 1'b1; tx_ack = 1'b0;
    tick(); tick();
    reset = 1'b0;
    in_data = 32'hDEAD_BEEF; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("t6_tx_req", tx_req, 1);
    tick(); tick();
    reset = 1'b1;
    #1;
    chk("t6_rst_req",   tx_req,   0);
    chk("t6_rst_data",  tx_data,  0);
    chk("t6_rst_ready", in_ready, 1);
    tick();
    reset = 1'b0; tx_ack = 1'b1;
    n_done = 0; n_pe = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (done) n_done++;
      if (proto_err) n_pe++;
    end
    chk("t6_no_done", n_done, 0);
    chk("t6_perr",    n_pe,   1);
    chk("t6_req_idle", tx_req, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
